booth_radix4_mult: RTL
======================

// Module: booth_radix4_mult
// PURPOSE
//  Sequential radix-4 Booth multiplier, WIDTH-parametrised, retiring 2 multiplier bits per cycle.
//  Per-operation signed/unsigned mode; valid/ready handshake on input and output.
//  Drop-in arithmetic unit for datapaths needing an exact 2*WIDTH product at low area.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be even and >= 4 (elaboration error otherwise)
// PORTS
//  clk          in   1        rising-edge clock; the only clock
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        operands/mode valid
//  in_ready     out  1        block can accept operands (high only in IDLE)
//  a            in   WIDTH    multiplicand
//  b            in   WIDTH    multiplier
//  signed_mode  in   1        1: a, b two's complement; 0: a, b unsigned
//  out_valid    out  1        product valid
//  out_ready    in   1        consumer takes product
//  product      out  2*WIDTH  exact product, signed or unsigned per captured mode
//  busy         out  1        high in CALC or DONE
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE, in_ready=1, out_valid=0, busy=0, product=0.
//  rst wins over every other input; mid-CALC/DONE reset aborts, result discarded.
//  N = WIDTH/2 + 1 iterations (WIDTH=8 -> N=5).
//  States:
//   IDLE: in_ready=1. If in_valid: capture a, b, signed_mode, go to CALC.
//   CALC: one Booth step per cycle; after the Nth step, register product, go to DONE.
//   DONE: out_valid=1, product held stable; on out_ready go to IDLE.
//  Latency: accept at edge k -> out_valid first high in the cycle after edge k+N.
//  No accept in DONE, even when out_ready=1 (in_ready=0).
//  Throughput: at most one op per N+2 cycles.
//  Operand capture:
//   M = a and Q = b, each extended to WIDTH+2 bits; sign-extended if signed_mode, else zero-extended.
//   Accumulator A is WIDTH+4 bits and clears to 0. Guard bit q_m1 clears to 0.
//  Each CALC step, triplet t = {Q[1],Q[0],q_m1}:
//   000/111: +0;  001/010: +M;  011: +2M;  100: -2M;  101/110: -M.
//   Add into A (M sign-extended to A width); then arithmetic-shift {A,Q,q_m1} right by 2.
//  Step counter counts N down to 0; it wraps back only via a new accept.
//  Result: product = {A,Q}[2*WIDTH-1:0] after the Nth step; always exact, no overflow in either mode.
//  Inputs a, b, signed_mode are ignored outside the IDLE accept cycle.
//  product keeps the last result after handoff until the next result or rst.
//  busy = (state != IDLE).
// TESTING (WIDTH=8 unless noted)
//  Latency/corner:
//   signed -128 * -128 -> product=16'h4000; out_valid exactly 5 cycles after the accept edge.
//  Mode:
//   unsigned 255*255 -> 16'hFE01.
//   Same bits in signed mode (-1*-1) -> 16'h0001.
//  Mixed sign:
//   signed -7*3 -> 16'hFFEB.
//   signed 127*-128 -> 16'hC080.
//   unsigned 0*200 -> 16'h0000.
//  Back-pressure:
//   hold out_ready=0 for 10 cycles -> out_valid=1 and product stable throughout, in_ready=0.
//   Toggling in_valid, a, b has no effect.
//  Reset mid-op:
//   rst at 2nd CALC cycle -> next cycle in_ready=1, out_valid=0, busy=0, product=0.
//   Following op 5*6 -> 16'h001E.
//  Random:
//   1000 ops per mode at WIDTH=8 and WIDTH=16 against a behavioural model.
//   Random in_valid/out_ready gaps; zero mismatches.

Source files
------------

// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier.
// Retires two multiplier bits per cycle. Signed or unsigned mode is chosen per operation.
// Both sides use a valid/ready handshake. Every product is exact over 2*WIDTH bits.
module booth_radix4_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    // Operands are widened by two bits so the unsigned case is also a non-negative
    // two's complement value. The accumulator has two further bits of headroom to hold +/-2M.
    localparam int QW = WIDTH + 2;
    localparam int AW = WIDTH + 4;
    localparam int SW = AW + QW + 1;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);

    generate
        if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
            $error("booth_radix4_mult: WIDTH must be even and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [QW-1:0]   mcand;
    logic [QW-1:0]   q;
    logic            qm1;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [QW-1:0]   a_ext;
    logic [QW-1:0]   b_ext;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [SW-1:0]   shifted;
    logic [AW+QW-1:0] aq_nxt;
    logic [AW-1:0]   acc_nxt;
    logic [QW-1:0]   q_nxt;
    logic            qm1_nxt;
    logic [2*WIDTH-1:0] prod_nxt;

    // Extend the operands according to the requested mode. After capture the mode
    // is only present in the extension bits, so it does not need its own register.
    always_comb begin
        if (signed_mode) begin
            a_ext = {{2{a[WIDTH-1]}}, a};
            b_ext = {{2{b[WIDTH-1]}}, b};
        end else begin
            a_ext = {2'b00, a};
            b_ext = {2'b00, b};
        end
    end

    // One Booth step: select a partial product from the recoded triplet, add it,
    // then arithmetic-shift {A,Q,q_m1} right by two.
    always_comb begin
        m_ext = {{2{mcand[QW-1]}}, mcand};
        addend = '0;
        case ({q[1:0], qm1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum      = acc + addend;
        shifted  = $signed({sum, q, qm1}) >>> 2;
        aq_nxt   = shifted[SW-1:1];
        acc_nxt  = aq_nxt[AW+QW-1:QW];
        q_nxt    = aq_nxt[QW-1:0];
        qm1_nxt  = shifted[0];
        prod_nxt = aq_nxt[2*WIDTH-1:0];
    end

    // Control FSM with registered handshake outputs. The datapath registers are updated here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            product   <= '0;
            mcand     <= '0;
            q         <= '0;
            qm1       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a_ext;
                        q        <= b_ext;
                        qm1      <= 1'b0;
                        acc      <= '0;
                        cnt      <= CW'(N);
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    qm1 <= qm1_nxt;
                    cnt <= cnt - 1'b1;
                    // The final step writes the product directly, so out_valid rises on that same edge.
                    if (cnt == CW'(1)) begin
                        product   <= prod_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
